// File: rtl/video_source_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : video_source_arbiter                                       |
// | Description : Frame-aligned two-source video arbiter; the grant moves    |
// |               only on the last ready of a frame, output is registered.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module video_source_arbiter #(
    parameter int VISIBLE_WIDTH  = 800,
    parameter int VISIBLE_HEIGHT = 600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        VideoReady,
    input  logic        SrcSel,
    output logic        ReadyA,
    output logic        ReadyB,
    input  logic        ValidA,
    input  logic        ValidB,
    input  logic [23:0] VideoA,
    input  logic [23:0] VideoB,
    output logic        VideoValid,
    output logic [23:0] Video,
    output logic        ActiveSrc,
    output logic        SwitchPulse
);

    localparam int         c_CNT_W  = 10;
    localparam logic [9:0] c_H_LAST = 10'(VISIBLE_WIDTH - 1);
    localparam logic [9:0] c_V_LAST = 10'(VISIBLE_HEIGHT - 1);

    typedef enum logic [0:0] {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_grant_d;
    logic [c_CNT_W-1:0]   r_h_cnt;
    logic [c_CNT_W-1:0]   r_v_cnt;
    logic                 r_video_valid;
    logic [23:0]          r_video;
    logic                 r_switch;

    logic                 w_h_last;
    logic                 w_boundary;
    state_t               w_req_state;

    assign w_h_last    = (r_h_cnt == c_H_LAST);
    assign w_boundary  = VideoReady && w_h_last && (r_v_cnt == c_V_LAST);
    assign w_req_state = SrcSel ? GRANT_B : GRANT_A;

    // Only the granted source ever sees a ready.
    assign ReadyA = VideoReady && (r_state == GRANT_A);
    assign ReadyB = VideoReady && (r_state == GRANT_B);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= GRANT_A;
            r_grant_d     <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_video_valid <= 1'b0;
            r_video       <= 24'h0;
            r_switch      <= 1'b0;
        end else begin
            r_grant_d <= (r_state == GRANT_B);
            r_switch  <= 1'b0;

            if (VideoReady) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end

            // SrcSel is sampled only on the frame's final issue; earlier requests are ignored.
            case (r_state)
                GRANT_A: if (w_boundary && w_req_state == GRANT_B) begin
                    r_state  <= GRANT_B;
                    r_switch <= 1'b1;
                end
                GRANT_B: if (w_boundary && w_req_state == GRANT_A) begin
                    r_state  <= GRANT_A;
                    r_switch <= 1'b1;
                end
                default: r_state <= GRANT_A;
            endcase

            // Delayed grant so the old source's trailing valid still lands after a switch.
            r_video_valid <= r_grant_d ? ValidB : ValidA;
            r_video       <= r_grant_d ? VideoB : VideoA;
        end
    end

    assign VideoValid  = r_video_valid;
    assign Video       = r_video;
    assign ActiveSrc   = (r_state == GRANT_B);
    assign SwitchPulse = r_switch;

endmodule

`default_nettype wire
